// File: rtl/pc_redirect_unit.sv
// Next-PC generator: fetch PC register with an N-channel prioritised redirect mux.
// Latency: a redirect valid at edge k reaches pc after edge k, or after the first unstalled edge after that.
// Backpressure: stall holds pc; a redirect raised during a stall is buffered and applied on release.
//
// Ports:
//   clk_i            rising-edge clock
//   reset_i          synchronous, active-high reset
//   stall_i          D-stage hazard stall; holds pc
//   redir_valid_i    per-channel redirect request, channel 0 highest priority
//   redir_target_i   channel i target at [i*WIDTH +: WIDTH]
//   exc_req_i        exception request (present only when PC_EXC_EN is defined)
//   pc_o             current fetch PC (registered)
//   pc_next_o        value pc_o takes at the next edge (combinational)
//   pc8_o            pc_o + 8, the jal link value (combinational, wraps)
//   redir_pending_o  a buffered redirect is waiting (registered)
//   align_err_o      previous edge loaded a target with nonzero [1:0] (registered)
//
// Build option: define PC_EXC_EN to add exc_req_i and the exception-vector path.
// Without it, EXC_VEC is ignored and exceptions are not handled here.

module pc_redirect_unit #(
    parameter int unsigned           WIDTH    = 32,
    parameter int unsigned           NSRC     = 4,
    parameter logic [WIDTH-1:0]      RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0]      EXC_VEC  = WIDTH'(32'h0000_4180)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     stall_i,
    input  logic [NSRC-1:0]          redir_valid_i,
    input  logic [NSRC*WIDTH-1:0]    redir_target_i,
`ifdef PC_EXC_EN
    input  logic                     exc_req_i,
`endif
    output logic [WIDTH-1:0]         pc_o,
    output logic [WIDTH-1:0]         pc_next_o,
    output logic [WIDTH-1:0]         pc8_o,
    output logic                     redir_pending_o,
    output logic                     align_err_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pc_q,          pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_vld_q,    pend_vld_d;
    logic             align_err_q,   align_err_d;

    // ------------------------------------------------------------------
    // Exception request: tied off when the feature is not built in.
    // ------------------------------------------------------------------
    logic exc_take;

`ifdef PC_EXC_EN
    assign exc_take = exc_req_i;
`else
    assign exc_take = 1'b0;

    // EXC_VEC has no consumer in this build; fold it into a deliberately
    // unused net so the parameter stays part of the interface.
    logic unused_exc_vec;
    assign unused_exc_vec = ^EXC_VEC;
`endif

    // ------------------------------------------------------------------
    // Redirect channel select
    // ------------------------------------------------------------------
    logic             new_redir;     // any channel requesting this cycle
    logic [WIDTH-1:0] sel_target;    // raw target of the winning channel
    logic [WIDTH-1:0] sel_aligned;   // winning target with [1:0] cleared
    logic             sel_misalign;  // winning target had [1:0] != 0

    assign new_redir = |redir_valid_i;

    // Walk from the highest index down so the lowest-index valid channel
    // is the last assignment and therefore wins.
    always_comb begin
        sel_target = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (redir_valid_i[i]) begin
                sel_target = redir_target_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_aligned  = {sel_target[WIDTH-1:2], 2'b00};
    assign sel_misalign = |sel_target[1:0];

    // ------------------------------------------------------------------
    // Sequential increments (modulo 2^WIDTH, carry discarded)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_plus8;

    assign pc_plus4 = pc_q + WIDTH'(4);
    assign pc_plus8 = pc_q + WIDTH'(8);

    // ------------------------------------------------------------------
    // Next-state selection. Reset is folded in here too so that pc_next_o
    // always equals the value pc_o shows after the coming edge.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_vld_d    = pend_vld_q;
        align_err_d   = 1'b0;

        if (reset_i) begin
            pc_d          = RESET_PC;
            pend_target_d = '0;
            pend_vld_d    = 1'b0;
        end else if (exc_take) begin
            // Exceptions override stalls and drop any buffered redirect.
            pc_d       = EXC_VEC;
            pend_vld_d = 1'b0;
        end else if (stall_i) begin
            // pc holds; the newest request replaces whatever is buffered.
            if (new_redir) begin
                pend_target_d = sel_aligned;
                pend_vld_d    = 1'b1;
                align_err_d   = sel_misalign;
            end
        end else if (new_redir) begin
            // A fresh request is younger than the buffered one, so it wins.
            pc_d        = sel_aligned;
            pend_vld_d  = 1'b0;
            align_err_d = sel_misalign;
        end else if (pend_vld_q) begin
            // Buffered target was aligned when captured; no error here.
            pc_d       = pend_target_q;
            pend_vld_d = 1'b0;
        end else begin
            pc_d = pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            pend_vld_q    <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_vld_q    <= pend_vld_d;
            align_err_q   <= align_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_o            = pc_q;
    assign pc_next_o       = pc_d;
    assign pc8_o           = pc_plus8;
    assign redir_pending_o = pend_vld_q;
    assign align_err_o     = align_err_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Ends with a single CHECKS/ERRORS summary line.

module tb_pc_redirect_unit;

    localparam int WIDTH = 32;
    localparam int NSRC  = 4;

    logic                  clk;
    logic                  reset;
    logic                  stall;
    logic [NSRC-1:0]       redir_valid;
    logic [NSRC*WIDTH-1:0] redir_target;
`ifdef PC_EXC_EN
    logic                  exc_req;
`endif
    logic [WIDTH-1:0]      pc;
    logic [WIDTH-1:0]      pc_next;
    logic [WIDTH-1:0]      pc8;
    logic                  redir_pending;
    logic                  align_err;

    int checks;
    int errors;

    pc_redirect_unit #(
        .WIDTH    (WIDTH),
        .NSRC     (NSRC),
        .RESET_PC (32'h0000_3000),
        .EXC_VEC  (32'h0000_4180)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .stall_i         (stall),
        .redir_valid_i   (redir_valid),
        .redir_target_i  (redir_target),
`ifdef PC_EXC_EN
        .exc_req_i       (exc_req),
`endif
        .pc_o            (pc),
        .pc_next_o       (pc_next),
        .pc8_o           (pc8),
        .redir_pending_o (redir_pending),
        .align_err_o     (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] tgt);
        redir_target[ch*WIDTH +: WIDTH] = tgt;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        stall        = 1'b0;
        redir_valid  = '0;
        redir_target = '0;
`ifdef PC_EXC_EN
        exc_req      = 1'b0;
`endif

        // ---------------- reset state ----------------
        step();
        chk("rst_pc",      pc,            32'h0000_3000);
        chk("rst_pend",    {31'b0, redir_pending}, 32'd0);
        chk("rst_align",   {31'b0, align_err},     32'd0);
        chk("rst_pc8",     pc8,           32'h0000_3008);
        reset = 1'b0;
        #1;
        chk("free_next",   pc_next,       32'h0000_3004);

        // ---------------- three free edges ----------------
        step(); chk("free1",   pc, 32'h0000_3004);
        step(); chk("free2",   pc, 32'h0000_3008);
        step(); chk("free3",   pc, 32'h0000_300C);
        chk("free3_pc8",   pc8,           32'h0000_3014);
        chk("free3_pend",  {31'b0, redir_pending}, 32'd0);

        // ---------------- priority: ch1 beats ch2 ----------------
        set_ch(1, 32'h0000_3100);
        set_ch(2, 32'h0000_3200);
        redir_valid = 4'b0110;
        #1;
        chk("prio_next",   pc_next,       32'h0000_3100);
        step();
        chk("prio_pc",     pc,            32'h0000_3100);
        redir_valid = '0;

        // ---------------- stall buffers a redirect ----------------
        stall = 1'b1;
        set_ch(3, 32'h0000_3400);
        redir_valid = 4'b1000;
        step();
        chk("stl1_pc",     pc,            32'h0000_3100);
        chk("stl1_pend",   {31'b0, redir_pending}, 32'd1);
        redir_valid = '0;
        #1;
        chk("stl_next",    pc_next,       32'h0000_3100);
        step();
        step();
        chk("stl3_pc",     pc,            32'h0000_3100);
        chk("stl3_pend",   {31'b0, redir_pending}, 32'd1);
        stall = 1'b0;
        #1;
        chk("rel_next",    pc_next,       32'h0000_3400);
        step();
        chk("rel_pc",      pc,            32'h0000_3400);
        chk("rel_pend",    {31'b0, redir_pending}, 32'd0);
        step();
        chk("rel_inc",     pc,            32'h0000_3404);

        // ---------------- new request beats pending ----------------
        stall = 1'b1;
        redir_valid = 4'b1000;
        step();
        redir_valid = '0;
        step();
        stall = 1'b0;
        set_ch(0, 32'h0000_3500);
        redir_valid = 4'b0001;
        step();
        chk("newwin_pc",   pc,            32'h0000_3500);
        chk("newwin_pend", {31'b0, redir_pending}, 32'd0);
        redir_valid = '0;
        step();
        chk("newwin_inc",  pc,            32'h0000_3504);

        // ---------------- misaligned target ----------------
        set_ch(0, 32'h0000_3303);
        redir_valid = 4'b0001;
        step();
        chk("mis_pc",      pc,            32'h0000_3300);
        chk("mis_err",     {31'b0, align_err}, 32'd1);
        redir_valid = '0;
        step();
        chk("mis_err_clr", {31'b0, align_err}, 32'd0);
        chk("mis_inc",     pc,            32'h0000_3304);

        // Misaligned target captured into the buffer during a stall.
        stall = 1'b1;
        set_ch(2, 32'h0000_3207);
        redir_valid = 4'b0100;
        step();
        chk("mis_stl_err", {31'b0, align_err}, 32'd1);
        chk("mis_stl_pc",  pc,            32'h0000_3304);
        redir_valid = '0;
        stall = 1'b0;
        step();
        chk("mis_rel_pc",  pc,            32'h0000_3204);
        chk("mis_rel_err", {31'b0, align_err}, 32'd0);

        // ---------------- wraparound ----------------
        set_ch(0, 32'hFFFF_FFFC);
        redir_valid = 4'b0001;
        step();
        chk("wrap_pc",     pc,            32'hFFFF_FFFC);
        chk("wrap_pc8",    pc8,           32'h0000_0004);
        redir_valid = '0;
        step();
        chk("wrap_zero",   pc,            32'h0000_0000);

        // ---------------- reset mid-stall discards pending ----------------
        stall = 1'b1;
        redir_valid = 4'b1000;
        step();
        chk("rs_pend",     {31'b0, redir_pending}, 32'd1);
        redir_valid = '0;
        reset = 1'b1;
        #1;
        chk("rs_next",     pc_next,       32'h0000_3000);
        step();
        chk("rs_pc",       pc,            32'h0000_3000);
        chk("rs_pend_clr", {31'b0, redir_pending}, 32'd0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        chk("rs_after",    pc,            32'h0000_3004);

`ifdef PC_EXC_EN
        // ---------------- exception during stall ----------------
        stall = 1'b1;
        redir_valid = 4'b1000;
        step();
        redir_valid = '0;
        exc_req = 1'b1;
        step();
        chk("exc_pc",      pc,            32'h0000_4180);
        chk("exc_pend",    {31'b0, redir_pending}, 32'd0);
        exc_req = 1'b0;
        stall = 1'b0;
        step();
        chk("exc_inc",     pc,            32'h0000_4184);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls on the clock.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
